gpr_bank: RTL
=============

GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 SHALL take parameter WIDTH, default 32; data width of every register and data port.
REQ-002 SHALL take parameter NREGS, default 16; register count, power of two, at least 2.
REQ-003 SHALL derive local parameter AW = clog2(NREGS), the register-address width.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 clear  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  AW  write target.
REQ-008 BusMuxOut  input  WIDTH  write data.
REQ-009 rsv_en  input  1  reserve strobe; marks a register pending.
REQ-010 rsv_addr  input  AW  reserve target.
REQ-011 rd_a_addr, rd_b_addr  input  AW each  read addresses for ports A and B.
REQ-012 BAout  input  1  base-address mode; forces register 0 to read as zero.
REQ-013 rd_a_data, rd_b_data  output  WIDTH each  registered read data.
REQ-014 rd_a_pend, rd_b_pend  output  1 each  registered pending flag of the addressed register.

Function
REQ-015 SHALL store NREGS words of WIDTH bits; on a clock edge with wr_en=1, reg[wr_addr] takes BusMuxOut.
REQ-016 SHALL have a read latency of exactly one cycle: the address and BAout sampled at edge N appear on rd_*_data and rd_*_pend after edge N.
REQ-017 SHALL forward write data: if wr_en=1 and wr_addr equals a read address at the same edge, that port outputs BusMuxOut, not the old contents.
REQ-018 SHALL force a port's data to zero when BAout=1 and that port's read address is 0, overriding both forwarding and stored data; rd_*_pend is unaffected.
REQ-019 SHALL treat register 0 as a normal register for writes, reservations and pending flags; only the read value is gated by BAout.
REQ-020 SHALL keep one pending bit per register: rsv_en sets pend[rsv_addr]; wr_en clears pend[wr_addr].
REQ-021 SHALL leave pend set when a write and a reservation hit the same register at the same edge (reserve wins).
REQ-022 SHALL forward pending flags like data: the pend output reflects the same-edge write and reservation updates to the addressed register.
REQ-023 SHALL let both ports read the same address with identical results.
REQ-024 SHALL accept writes and reservations with no backpressure; there is no stall output.

Reset
REQ-025 SHALL, on clear=1 at an edge, zero all registers, all pend bits, rd_a_data, rd_b_data, rd_a_pend and rd_b_pend.
REQ-026 SHALL give clear priority over wr_en and rsv_en at the same edge; those operations are discarded.
REQ-027 SHALL output zeros on the cycle after a clear edge, regardless of addresses and BAout.

Structure
REQ-028 SHALL place the default WIDTH and NREGS constants in the shared CPU package cpu_pkg, alongside the register-index constant for R0 (value 0).
REQ-029 SHALL implement the per-port read, forward and BA-gate logic as one sub-module, gpr_read_port, instantiated twice.
REQ-030 SHALL contain no latches; the storage array and pend vector are the only state besides the output registers.

Verification
REQ-031 SHALL cover basic write/read: write 0xDEADBEEF to r5, then read A=5 the next cycle -> rd_a_data=0xDEADBEEF one cycle later, rd_a_pend=0.
REQ-032 SHALL cover forwarding: same edge wr r3=0x12345678 and rd_b_addr=3 -> rd_b_data=0x12345678 after that edge.
REQ-033 SHALL cover BA gating: r0=0x000000FF, then read A=0 and B=0 with BAout=1 -> both outputs 0; repeat with BAout=0 -> both 0x000000FF.
REQ-034 SHALL cover the pending lifecycle: rsv r7, then read 7 -> pend=1; write r7=0xA5 -> pend=0; simultaneous rsv r7 and wr r7 -> pend=1 and data=0xA5.
REQ-035 SHALL cover clear mid-operation: registers loaded and r2 pending, then assert clear together with wr r2=0x55 -> every register reads 0 with pend 0 in the following cycles.
REQ-036 SHALL cover parameter sweep: WIDTH=16, NREGS=4; write r3=0xFFFF -> reads back 0xFFFF; address wrap not possible (AW=2).

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for the register bank
package cpu_pkg;
    localparam int GPR_WIDTH = 32;
    localparam int GPR_NREGS = 16;
    localparam int R0 = 0;
endpackage

// File: rtl/gpr_read_port.sv
// gpr_read_port: registered read with same-edge write/reserve forwarding and BA gating of r0
module gpr_read_port
    import cpu_pkg::*;
#(
    parameter int WIDTH = GPR_WIDTH,
    parameter int NREGS = GPR_NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [AW-1:0]    addr,
    input  logic             BAout,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [WIDTH-1:0] regs [NREGS],
    input  logic [NREGS-1:0] pend,
    output logic [WIDTH-1:0] data,
    output logic             pending
);
    logic             wr_hit, rsv_hit, ba_zero, pend_d;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        wr_hit  = wr_en && wr_addr == addr;
        rsv_hit = rsv_en && rsv_addr == addr;
        ba_zero = BAout && addr == AW'(R0);
        data_d  = ba_zero ? '0 : wr_hit ? wr_data : regs[addr];
        pend_d  = rsv_hit | (!wr_hit & pend[addr]);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            data    <= '0;
            pending <= 1'b0;
        end else begin
            data    <= data_d;
            pending <= pend_d;
        end
    end
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: general-purpose register file with pending bits and two registered read ports
module gpr_bank
    import cpu_pkg::*;
#(
    parameter int WIDTH = GPR_WIDTH,
    parameter int NREGS = GPR_NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] BusMuxOut,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    input  logic             BAout,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_a_pend,
    output logic             rd_b_pend
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pend, wr_mask, rsv_mask;

    always_comb begin
        wr_mask  = wr_en ? NREGS'(1) << wr_addr : '0;
        rsv_mask = rsv_en ? NREGS'(1) << rsv_addr : '0;
    end

    // reservation is OR-ed in after the write clears, so reserve wins on a tie
    always_ff @(posedge clock) begin
        if (clear) begin
            regs <= '{default: '0};
            pend <= '0;
        end else begin
            if (wr_en) regs[wr_addr] <= BusMuxOut;
            pend <= (pend & ~wr_mask) | rsv_mask;
        end
    end

    gpr_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_a (
        .clock(clock), .clear(clear), .addr(rd_a_addr), .BAout(BAout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(BusMuxOut),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .regs(regs), .pend(pend),
        .data(rd_a_data), .pending(rd_a_pend)
    );

    gpr_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_port_b (
        .clock(clock), .clear(clear), .addr(rd_b_addr), .BAout(BAout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(BusMuxOut),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .regs(regs), .pend(pend),
        .data(rd_b_data), .pending(rd_b_pend)
    );
endmodule
